// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// addsub_pkg -- op encodings, FSM states and slice width for addsub_sliced
// Rev 1.0
// ============================================================================
package addsub_pkg;

    localparam int SLICE = 4;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ADD_SAT = 2'b10,
        OP_SUB_SAT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic op_is_sub(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SUB_SAT);
    endfunction

    function automatic logic op_is_sat(input logic [1:0] op);
        return (op == OP_ADD_SAT) || (op == OP_SUB_SAT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_slice.sv
`default_nettype none
// ============================================================================
// adder_slice -- W-bit ripple slice with carry in/out
// Rev 1.0
// ============================================================================
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W:0] w_total;

    assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
    assign o_sum   = w_total[W-1:0];
    assign o_cout  = w_total[W];

endmodule
`default_nettype wire

// File: rtl/addsub_sliced.sv
`default_nettype none
// ============================================================================
// addsub_sliced -- serial add/sub, one 4-bit slice per cycle, optional saturation
// Rev 1.0
// ============================================================================
module addsub_sliced
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_n,
    output logic             flag_z
);

    localparam int NSLICE  = WIDTH / SLICE;
    localparam int c_idx_w = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NSLICE - 1);
    localparam logic [WIDTH-1:0]   c_max_pos  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   c_max_neg  = {1'b1, {(WIDTH-1){1'b0}}};

    state_e               r_state;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_carry;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_sat;
    logic [WIDTH-1:0]     r_res;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_flag_c;
    logic                 r_flag_v;
    logic                 r_flag_n;
    logic                 r_flag_z;

    logic [SLICE-1:0]     w_a_sl;
    logic [SLICE-1:0]     w_b_sl;
    logic [SLICE-1:0]     w_sum_sl;
    logic                 w_cout;
    logic [WIDTH-1:0]     w_raw;
    logic [WIDTH-1:0]     w_final;
    logic                 w_v;

    assign w_a_sl = r_a[int'(r_idx)*SLICE +: SLICE];
    assign w_b_sl = r_b[int'(r_idx)*SLICE +: SLICE];

    adder_slice #(.W(SLICE)) u_slice (
        .i_a    (w_a_sl),
        .i_b    (w_b_sl),
        .i_cin  (r_carry),
        .o_sum  (w_sum_sl),
        .o_cout (w_cout)
    );

    // r_b already holds the effective (possibly inverted) operand, so overflow
    // and saturation treat ADD and SUB identically.
    always_comb begin
        w_raw = r_res;
        w_raw[int'(r_idx)*SLICE +: SLICE] = w_sum_sl;
        w_v = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_raw[WIDTH-1] != r_a[WIDTH-1]);
        w_final = w_raw;
        if (r_sat && w_v) begin
            w_final = r_a[WIDTH-1] ? c_max_neg : c_max_pos;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sat       <= 1'b0;
            r_res       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_flag_c    <= 1'b0;
            r_flag_v    <= 1'b0;
            r_flag_n    <= 1'b0;
            r_flag_z    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= op_is_sub(op) ? ~b : b;
                        r_carry    <= op_is_sub(op);
                        r_sat      <= op_is_sat(op);
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_carry <= w_cout;
                    if (r_idx == c_last_idx) begin
                        r_res       <= w_final;
                        r_flag_c    <= w_cout;
                        r_flag_v    <= w_v;
                        r_flag_n    <= w_final[WIDTH-1];
                        r_flag_z    <= (w_final == '0);
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_res <= w_raw;
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_res;
    assign flag_c    = r_flag_c;
    assign flag_v    = r_flag_v;
    assign flag_n    = r_flag_n;
    assign flag_z    = r_flag_z;

endmodule
`default_nettype wire

// File: tb/tb_addsub_sliced.sv
`default_nettype none
// ============================================================================
// tb_addsub_sliced -- scoreboard bench for addsub_sliced (WIDTH=16 and WIDTH=8)
// Rev 1.0
// ============================================================================
module tb_addsub_sliced;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        c, v, n, z;
    } vec_t;

    typedef struct {
        logic [7:0] r;
        logic       c, v, n, z;
    } exp8_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  op;
    logic [15:0] a, b, result;
    logic        flag_c, flag_v, flag_n, flag_z;

    logic        in_valid8, in_ready8, out_valid8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, result8;
    logic        flag_c8, flag_v8, flag_n8, flag_z8;

    int errors = 0;
    int checks = 0;

    vec_t  sb16[$];
    exp8_t sb8[$];
    vec_t  vecs[9];

    always #5 clk = ~clk;

    addsub_sliced #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_c(flag_c), .flag_v(flag_v), .flag_n(flag_n), .flag_z(flag_z)
    );

    addsub_sliced #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready),
        .result(result8), .flag_c(flag_c8), .flag_v(flag_v8), .flag_n(flag_n8), .flag_z(flag_z8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each rising out_valid; latency is counted
    // in negedges from the sample where the accept condition was seen.
    int  nc = 0, acc16 = 0, acc8 = 0;
    bit  pv16 = 1'b0, pv8 = 1'b0;
    always @(negedge clk) begin
        vec_t  e;
        exp8_t e8;
        nc++;
        if (!rst_n) begin
            pv16 = 1'b0;
            pv8  = 1'b0;
        end else begin
            if (in_valid && in_ready)   acc16 = nc;
            if (in_valid8 && in_ready8) acc8  = nc;
            if (out_valid && !pv16) begin
                if (sb16.size() == 0) begin
                    chk("unexpected_out_valid16", 32'd1, 32'd0);
                end else begin
                    e = sb16.pop_front();
                    chk($sformatf("res16 op%0d %h,%h", e.op, e.a, e.b), 32'(result), 32'(e.r));
                    chk($sformatf("c16 %h,%h", e.a, e.b), 32'(flag_c), 32'(e.c));
                    chk($sformatf("v16 %h,%h", e.a, e.b), 32'(flag_v), 32'(e.v));
                    chk($sformatf("n16 %h,%h", e.a, e.b), 32'(flag_n), 32'(e.n));
                    chk($sformatf("z16 %h,%h", e.a, e.b), 32'(flag_z), 32'(e.z));
                    chk("latency16", 32'(nc - acc16), 32'd5);
                end
            end
            if (out_valid8 && !pv8) begin
                if (sb8.size() == 0) begin
                    chk("unexpected_out_valid8", 32'd1, 32'd0);
                end else begin
                    e8 = sb8.pop_front();
                    chk("res8", 32'(result8), 32'(e8.r));
                    chk("c8", 32'(flag_c8), 32'(e8.c));
                    chk("v8", 32'(flag_v8), 32'(e8.v));
                    chk("n8", 32'(flag_n8), 32'(e8.n));
                    chk("z8", 32'(flag_z8), 32'(e8.z));
                    chk("latency8", 32'(nc - acc8), 32'd3);
                end
            end
            pv16 = out_valid;
            pv8  = out_valid8;
        end
    end

    // Present operands until accepted; returns at posedge+1 with in_valid low.
    task automatic accept16(input vec_t t);
        int n;
        op = t.op; a = t.a; b = t.b; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("accept_timeout16", 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out16();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("out_valid_timeout16", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic issue16(input vec_t t);
        sb16.push_back(t);
        accept16(t);
        wait_out16();
    endtask

    initial begin : main
        vec_t  t;
        exp8_t x8;
        int    n;

        vecs[0] = '{2'b00, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{2'b01, 16'h0007, 16'h0007, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{2'b10, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{2'b11, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{2'b10, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{2'b11, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 2'b00; a = '0; b = '0;
        in_valid8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_flags", 32'({flag_c, flag_v, flag_n, flag_z}), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_in_ready8", 32'(in_ready8), 32'd1);

        // WIDTH=8 operation
        x8 = '{8'h10, 1'b1, 1'b0, 1'b0, 1'b0};
        sb8.push_back(x8);
        @(posedge clk); #1;
        op8 = 2'b00; a8 = 8'hF0; b8 = 8'h20; in_valid8 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready8 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid8 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("out_valid_timeout8", 32'd1, 32'd0);
        @(posedge clk); #1;

        foreach (vecs[i]) issue16(vecs[i]);

        // Consumer stall in DONE while new operands are offered
        out_ready = 1'b0;
        sb16.push_back(vecs[0]);
        accept16(vecs[0]);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        op = vecs[1].op; a = vecs[1].a; b = vecs[1].b; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_result", 32'(result), 32'h2233);
            chk("hold_flags", 32'({flag_c, flag_v, flag_n, flag_z}), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        sb16.push_back(vecs[1]);
        @(posedge clk); #1;
        out_ready = 1'b1;
        accept16(vecs[1]);
        wait_out16();

        // Reset while slice 2 is in flight; this operation must never complete
        t = '{2'b00, 16'h1111, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0};
        accept16(t);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_result", 32'(result), 32'd0);
        chk("midrun_reset_flags", 32'({flag_c, flag_v, flag_n, flag_z}), 32'd0);
        chk("midrun_reset_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        issue16('{2'b00, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0});

        repeat (8) @(posedge clk);
        chk("scoreboard16_drained", 32'(sb16.size()), 32'd0);
        chk("scoreboard8_drained", 32'(sb8.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
